fifoctl: RTL and testbench
==========================

# fifoctl

Synchronous FIFO controller that sequences the single-clock `fifomem` dual-port RAM into a complete valid/ready stream FIFO. It owns the write and read pointers and the full/empty logic. It issues RAM reads ahead of demand and absorbs the RAM's `DELAY`-cycle read latency in a small output skid buffer. It sits between a producer and a consumer stream and drives the `fifomem` write and read ports directly.

## Interface
Parameters:
- `ADDW`, 4: RAM address bits.
- `DATW`, 8: data word width.
- `DELAY`, 1: RAM read latency in cycles, from `mem_radd` presented to `mem_rdat` valid. Legal range 1..3.
- `DEPTH`, `1<<ADDW`: RAM words. Not overridable independently.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `clr`  in  1  synchronous flush, active-high.
- `wr_vld`  in  1  producer word valid.
- `wr_dat`  in  `DATW`  producer word.
- `wr_rdy`  out  1  controller can accept a word.
- `rd_vld`  out  1  output word valid.
- `rd_dat`  out  `DATW`  output word.
- `rd_rdy`  in  1  consumer accepts the word.
- `level`  out  `ADDW+2`  words held: RAM + in flight + skid.
- `mem_wren`  out  1  to `fifomem` `wren`.
- `mem_wadd`  out  `ADDW`  to `fifomem` `wadd`.
- `mem_wdat`  out  `DATW`  to `fifomem` `wdata`.
- `mem_radd`  out  `ADDW`  to `fifomem` `radd`.
- `mem_rdat`  in  `DATW`  from `fifomem` `rdata`.

## Operation
- Pointers: `wptr` and `rptr` are `ADDW+1` bits each, with a wrap bit.
  - `mcnt = wptr - rptr`, modulo `2^(ADDW+1)`.
  - RAM full when `mcnt == DEPTH`; RAM empty when `mcnt == 0`.
- Write:
  - `wr_rdy = !full & !clr`.
  - `mem_wren = wr_vld & wr_rdy`, combinational.
  - `mem_wadd = wptr[ADDW-1:0]`; `mem_wdat = wr_dat`.
  - `wptr` increments on accept.
- Read issue:
  - `mem_radd = rptr[ADDW-1:0]` at all times.
  - Issue when `!empty & !clr & (infl + scnt - pop) < SKD`.
  - `SKD = DELAY+1`; `pop = rd_vld & rd_rdy`; `infl` = issued reads not yet returned; `scnt` = skid occupancy.
  - `rptr` increments on issue.
- Latency tracking: a `DELAY`-deep valid shift register marks each issue. When the mark reaches the end, `mem_rdat` is pushed into the skid.
- Skid: register FIFO of depth `SKD`.
  - `rd_vld = scnt != 0`; `rd_dat` = skid head, registered.
  - Overflow is impossible by the credit rule. The bench asserts this.
- Level: `level = mcnt + infl + scnt`. Maximum is `DEPTH + SKD`.
- Flush: `clr` has priority over all traffic.
  - Next cycle: pointers equal, shift register cleared, skid empty, `level == 0`.
  - A write presented during `clr` is refused (`wr_rdy` low).
  - In-flight RAM data is discarded.
- Simultaneous write and issue at full: issue frees no RAM slot in the same cycle; `wr_rdy` is computed from registered `mcnt` only.
- Simultaneous write and issue at empty: no issue. The write becomes visible to issue one cycle later, so read-during-write on the same address never occurs.
- Reset: `rst_n` low at an edge has the same effect as `clr`, plus all registers zeroed. This also holds when reset arrives mid-stream.

## Timing
- Reset values:
  - `wr_rdy` = 0 while `rst_n` low, 1 from the first cycle after release.
  - `rd_vld` = 0, `rd_dat` = 0, `level` = 0.
  - `mem_wren` = 0, `mem_radd` = 0, `mem_wadd` = 0.
- Fall-through latency, empty FIFO:
  - Write accepted in cycle N.
  - Issue in N+1.
  - `mem_rdat` valid in N+1+`DELAY`.
  - `rd_vld` in N+2+`DELAY`, i.e. N+3 for `DELAY`=1.
- Throughput: one word per cycle in and out in steady state, with `rd_rdy` held high, for every legal `DELAY`.
- Backpressure: while `rd_rdy` is low, `rd_vld`/`rd_dat` hold stable. After `SKD` words are buffered or in flight, no further issues occur.
- `clr` takes effect at the edge ending the cycle in which it is high.

## Structure
- Shared package/header `fifo_pkg` holds:
  - `SKD` derivation (`DELAY+1`).
  - level width (`ADDW+2`).
  - pointer-width helper.
  - legal-`DELAY` range check.
- One sub-module, `fifoskid`: parameterised register FIFO (`DATW`, depth `SKD`) with push/pop, count, and synchronous clear.
- `fifoctl` itself holds the pointers, credit logic and latency shift register. It does not instantiate `fifomem`; the enclosing top connects the `mem_*` ports.

## Test plan
- Reset then single write of 0xA5, `DELAY`=1 -> `rd_vld` rises exactly 3 cycles after the write; `rd_dat` = 0xA5; `level` goes 1,1,1,0 around the pop.
- Fill with `rd_rdy`=0, `ADDW`=4, `DELAY`=2 -> 16 words stored in RAM plus 3 in the skid; `wr_rdy` drops when `level` = 19; no skid overflow assertion fires.
- Continuous stream of 100 incrementing words with `rd_rdy`=1, `DELAY`=3 -> output identical and in order; after fill, one word per cycle with no bubbles.
- Random `wr_vld`/`rd_rdy` at 50% for 10k cycles, `DELAY`=1..3 -> scoreboard match; `level` equals the reference-model count every cycle.
- `clr` asserted with 7 words stored and 2 in flight, concurrent write attempt -> next cycle `level`=0, `rd_vld`=0; the write is refused; the next word written is the next word read.
- `rst_n` pulled low mid-stream for 1 cycle -> all outputs reach reset values at that edge; traffic resumes cleanly after release.

Source files
------------

// File: rtl/fifoctl_pkg.sv
// fifo_pkg: shared sizing helpers for the fifoctl stream FIFO controller
// No ports; holds the skid depth, level and pointer widths, and the legal DELAY range.
package fifo_pkg;
  function automatic int skd_depth(input int delay);
    return delay + 1;
  endfunction
  function automatic int lvl_w(input int addw);
    return addw + 2;
  endfunction
  function automatic int ptr_w(input int addw);
    return addw + 1;
  endfunction
  function automatic logic delay_ok(input int delay);
    return delay >= 1 && delay <= 3;
  endfunction
endpackage

// File: rtl/fifoctl_if.sv
// fifoctl_if: producer/consumer stream and fifomem port bundle for fifoctl
// slave  (controller): takes wr_vld/wr_dat/rd_rdy/mem_rdat; drives wr_rdy, rd_vld/rd_dat, level, mem_wren/wadd/wdat/radd.
// master (environment): the mirror image.
interface fifoctl_if import fifo_pkg::*; #(parameter int ADDW = 4, parameter int DATW = 8);
  logic wr_vld, wr_rdy, rd_vld, rd_rdy, mem_wren;
  logic [DATW-1:0] wr_dat, rd_dat, mem_wdat, mem_rdat;
  logic [lvl_w(ADDW)-1:0] level;
  logic [ADDW-1:0] mem_wadd, mem_radd;
  modport slave(input wr_vld, wr_dat, rd_rdy, mem_rdat,
                output wr_rdy, rd_vld, rd_dat, level, mem_wren, mem_wadd, mem_wdat, mem_radd);
  modport master(output wr_vld, wr_dat, rd_rdy, mem_rdat,
                 input wr_rdy, rd_vld, rd_dat, level, mem_wren, mem_wadd, mem_wdat, mem_radd);
endinterface

// File: rtl/fifoctl_skid.sv
// fifoskid: small register FIFO that catches RAM read data ahead of the consumer
// clk, rst_n (sync, active-low, zeroes storage), clr (sync flush), push/din in,
// pop in, dout = head word (registered), vld = non-empty, cnt = occupancy.
module fifoskid #(
  parameter int DATW = 8,
  parameter int DEPTH = 2,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            push,
  input  logic [DATW-1:0] din,
  input  logic            pop,
  output logic [DATW-1:0] dout,
  output logic            vld,
  output logic [CW-1:0]   cnt
);
  logic [DATW-1:0] mem [DEPTH];
  logic [DATW-1:0] nxt [DEPTH];
  logic [CW-1:0] wi;
  assign dout = mem[0];
  assign vld = cnt != '0;
  assign wi = cnt - CW'(pop);
  // head always lives in mem[0]; a pop shifts everything down one slot
  always_comb begin
    for (int i = 0; i < DEPTH; i++) nxt[i] = pop ? mem[(i + 1) % DEPTH] : mem[i];
    if (push) nxt[wi] = din;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt <= '0;
      mem <= '{default: '0};
    end else if (clr) cnt <= '0;
    else begin
      cnt <= cnt + CW'(push) - CW'(pop);
      mem <= nxt;
    end
endmodule

// File: rtl/fifoctl.sv
// fifoctl: valid/ready stream FIFO controller wrapped around a DELAY-latency fifomem RAM
// clk, rst_n (sync, active-low), clr (sync flush); bus.slave carries the producer
// stream (wr_*), consumer stream (rd_*), occupancy (level) and the fifomem ports (mem_*).
module fifoctl import fifo_pkg::*; #(
  parameter int ADDW = 4,
  parameter int DATW = 8,
  parameter int DELAY = 1
) (
  input logic      clk,
  input logic      rst_n,
  input logic      clr,
  fifoctl_if.slave bus
);
  localparam int DEPTH = 1 << ADDW;
  localparam int SKD = skd_depth(DELAY);
  localparam int PW = ptr_w(ADDW);
  localparam int LW = lvl_w(ADDW);
  if (!delay_ok(DELAY)) begin : g_bad_delay
    $error("fifoctl: DELAY must be in 1..3");
  end
  logic [PW-1:0] wptr, rptr, mcnt;
  logic [DELAY-1:0] sr;
  logic [LW-1:0] infl, scnt, cred;
  logic [$clog2(SKD+1)-1:0] sk_cnt;
  logic flush, full, empty, pop, iss;
  assign flush = clr | ~rst_n;
  assign mcnt = wptr - rptr;
  assign full = mcnt == PW'(DEPTH);
  assign empty = mcnt == '0;
  assign pop = bus.rd_vld & bus.rd_rdy;
  assign bus.wr_rdy = ~full & ~flush;
  assign bus.mem_wren = bus.wr_vld & bus.wr_rdy;
  assign bus.mem_wadd = wptr[ADDW-1:0];
  assign bus.mem_wdat = bus.wr_dat;
  assign bus.mem_radd = rptr[ADDW-1:0];
  assign scnt = LW'(sk_cnt);
  // every issued read owns a skid slot until it is popped, so the skid never overflows
  assign cred = infl + scnt - LW'(pop);
  assign iss = ~empty & ~flush & (cred < LW'(SKD));
  assign bus.level = LW'(mcnt) + infl + scnt;
  always_comb begin
    infl = '0;
    for (int i = 0; i < DELAY; i++) infl = infl + LW'(sr[i]);
  end
  always_ff @(posedge clk)
    if (flush) begin
      wptr <= '0;
      rptr <= '0;
      sr <= '0;
    end else begin
      wptr <= wptr + PW'(bus.mem_wren);
      rptr <= rptr + PW'(iss);
      sr <= DELAY'({sr, iss});
    end
  fifoskid #(.DATW(DATW), .DEPTH(SKD)) u_skid (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .push(sr[DELAY-1]), .din(bus.mem_rdat), .pop(pop),
    .dout(bus.rd_dat), .vld(bus.rd_vld), .cnt(sk_cnt)
  );
endmodule

// File: tb/tb_fifoctl.sv
// tb_fifoctl: random and directed checks of fifoctl for DELAY 1..3 against a queue model
module tb_fifoctl;
  import fifo_pkg::*;
  localparam int ADDW = 4, DATW = 8, DEPTH = 1 << ADDW, LW = ADDW + 2, RND = 10000;
  logic clk = 0;
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0;
  task automatic chk(input logic ok, input string name, input int d, input longint act, input longint exp);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s D=%0d got %0d want %0d", name, d, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  for (genvar g = 0; g < 3; g++) begin : g_d
    localparam int D = g + 1;
    localparam int SKD = skd_depth(D);
    localparam int MAXL = DEPTH + SKD;
    logic rst_n, clr;
    bit fin = 0;
    fifoctl_if #(.ADDW(ADDW), .DATW(DATW)) bus ();
    fifoctl #(.ADDW(ADDW), .DATW(DATW), .DELAY(D)) dut (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus));
    logic [DATW-1:0] ram [DEPTH];
    logic [DATW-1:0] pipe [D];
    always @(posedge clk) begin
      if (bus.mem_wren) ram[bus.mem_wadd] <= bus.mem_wdat;
      pipe[0] <= ram[bus.mem_radd];
      for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.mem_rdat = pipe[D-1];
    logic [DATW-1:0] q[$];
    logic hold;
    logic [DATW-1:0] hold_dat;
    int e;
    initial begin : cmp
      hold = 0;
      @(posedge clk);
      forever begin
        @(negedge clk);
        chk(bus.level == LW'(q.size()), "level", D, bus.level, q.size());
        e = q.size() != 0 ? int'(q[0]) : -1;
        if (bus.rd_vld) chk(q.size() != 0 && int'(bus.rd_dat) == e, "rd_dat", D, bus.rd_dat, e);
        if (hold) chk(bus.rd_vld && bus.rd_dat == hold_dat, "hold", D, bus.rd_dat, hold_dat);
        if (!rst_n || clr || q.size() >= MAXL) chk(!bus.wr_rdy, "wr_rdy_lo", D, bus.wr_rdy, 0);
        else if (q.size() < DEPTH) chk(bus.wr_rdy, "wr_rdy_hi", D, bus.wr_rdy, 1);
        chk(!(dut.u_skid.push && !dut.u_skid.pop && dut.u_skid.cnt == SKD), "skid_ovf", D, dut.u_skid.cnt, SKD);
        hold = bus.rd_vld && !bus.rd_rdy && rst_n && !clr;
        hold_dat = bus.rd_dat;
        if (!rst_n || clr) q.delete();
        else begin
          if (bus.rd_vld && bus.rd_rdy && q.size() != 0) void'(q.pop_front());
          if (bus.wr_vld && bus.wr_rdy) q.push_back(bus.wr_dat);
        end
      end
    end
    int n, acc, run, best;
    initial begin : stim
      rst_n = 0; clr = 0; bus.wr_vld = 0; bus.wr_dat = 0; bus.rd_rdy = 0;
      #1;
      chk(!bus.wr_rdy, "rst_wr_rdy", D, bus.wr_rdy, 0);
      step(); step();
      chk(bus.level == 0, "rst_level", D, bus.level, 0);
      chk(!bus.rd_vld, "rst_rd_vld", D, bus.rd_vld, 0);
      chk(bus.rd_dat == 0, "rst_rd_dat", D, bus.rd_dat, 0);
      chk(!bus.mem_wren, "rst_wren", D, bus.mem_wren, 0);
      chk(bus.mem_radd == 0 && bus.mem_wadd == 0, "rst_addr", D, bus.mem_radd, 0);
      rst_n = 1;
      step();
      chk(bus.wr_rdy, "rel_wr_rdy", D, bus.wr_rdy, 1);
      // single word fall-through
      bus.rd_rdy = 1; bus.wr_vld = 1; bus.wr_dat = 8'hA5;
      step();
      bus.wr_vld = 0; n = 1;
      while (!bus.rd_vld && n < 20) begin
        chk(bus.level == 1, "lat_level", D, bus.level, 1);
        step(); n++;
      end
      chk(n == D + 2, "latency", D, n, D + 2);
      chk(bus.rd_dat == 8'hA5, "ft_dat", D, bus.rd_dat, 8'hA5);
      chk(bus.level == 1, "ft_level", D, bus.level, 1);
      step();
      chk(bus.level == 0 && !bus.rd_vld, "ft_popped", D, bus.level, 0);
      // fill under backpressure
      bus.rd_rdy = 0; acc = 0;
      for (int i = 0; i < MAXL + 4; i++) begin
        bus.wr_vld = 1; bus.wr_dat = 8'(i + 16);
        #1;
        if (bus.wr_rdy) acc++;
        step();
      end
      bus.wr_vld = 0;
      repeat (D + 3) step();
      chk(acc == MAXL, "fill_acc", D, acc, MAXL);
      chk(bus.level == LW'(MAXL), "fill_level", D, bus.level, MAXL);
      chk(!bus.wr_rdy, "fill_full", D, bus.wr_rdy, 0);
      bus.rd_rdy = 1; n = 0;
      while (bus.level != 0 && n < 100) begin step(); n++; end
      chk(bus.level == 0, "drain", D, bus.level, 0);
      // continuous stream, no bubbles
      run = 0; best = 0;
      for (int i = 0; i < 100 + D + 10; i++) begin
        bus.wr_vld = i < 100; bus.wr_dat = 8'(i);
        #1;
        run = bus.rd_vld ? run + 1 : 0;
        if (run > best) best = run;
        step();
      end
      bus.wr_vld = 0;
      chk(best == 100, "stream_run", D, best, 100);
      // flush with words stored and in flight
      bus.rd_rdy = 0;
      for (int i = 0; i < 9; i++) begin
        bus.wr_vld = 1; bus.wr_dat = 8'(i + 64);
        step();
      end
      clr = 1; bus.wr_vld = 1; bus.wr_dat = 8'hEE;
      #1;
      chk(!bus.wr_rdy, "clr_refuse", D, bus.wr_rdy, 0);
      chk(!bus.mem_wren, "clr_wren", D, bus.mem_wren, 0);
      step();
      clr = 0; bus.wr_vld = 0;
      chk(bus.level == 0, "clr_level", D, bus.level, 0);
      chk(!bus.rd_vld, "clr_rd_vld", D, bus.rd_vld, 0);
      bus.wr_vld = 1; bus.wr_dat = 8'h3C; bus.rd_rdy = 1;
      step();
      bus.wr_vld = 0; n = 0;
      while (!bus.rd_vld && n < 20) begin step(); n++; end
      chk(bus.rd_vld && bus.rd_dat == 8'h3C, "clr_next", D, bus.rd_dat, 8'h3C);
      step(); step();
      // random traffic with a reset pulse in the middle
      for (int i = 0; i < RND; i++) begin
        bus.wr_vld = 1'($urandom_range(1));
        bus.wr_dat = 8'($urandom);
        bus.rd_rdy = 1'($urandom_range(1));
        clr = $urandom_range(199) == 0;
        if (i == RND / 2) begin
          clr = 0; rst_n = 0; bus.wr_vld = 1;
          #1;
          chk(!bus.wr_rdy, "mid_rst_wr_rdy", D, bus.wr_rdy, 0);
          chk(!bus.mem_wren, "mid_rst_wren", D, bus.mem_wren, 0);
          step();
          bus.wr_vld = 0;
          #1;
          chk(bus.level == 0, "mid_rst_level", D, bus.level, 0);
          chk(!bus.rd_vld && bus.rd_dat == 0, "mid_rst_rd", D, bus.rd_dat, 0);
          chk(bus.mem_radd == 0 && bus.mem_wadd == 0, "mid_rst_addr", D, bus.mem_wadd, 0);
          rst_n = 1;
        end
        step();
      end
      clr = 0; bus.wr_vld = 0; bus.rd_rdy = 1;
      repeat (MAXL + D + 5) step();
      chk(bus.level == 0, "final_level", D, bus.level, 0);
      fin = 1;
    end
  end
  initial begin
    fork
      wait (g_d[0].fin && g_d[1].fin && g_d[2].fin);
      #2000000;
    join_any
    if (!(g_d[0].fin && g_d[1].fin && g_d[2].fin)) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout fin=%0d%0d%0d want 111", g_d[0].fin, g_d[1].fin, g_d[2].fin);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
